usb_ep_status_bus: RTL and testbench

Bus-side requester for the endpoint-status RAM auxiliary port. Converts single-beat register-bus reads/writes from the SoC (CPU/wishbone shim) into held `s_*` requests, waits out `s_ready_0` backpressure caused by the priority (USB core) port, and returns read data from the port's fixed 3-cycle pipeline. It sits between the core's bus decoder and the aux port of the EP status memory. It also write-protects the microcode ROM region.

---
 rtl/usb_ep_status_bus_pkg.sv | 16 +
 rtl/usb_ep_status_bus.sv | 158 +++++++++++++++
 tb/tb_usb_ep_status_bus.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_ep_status_bus_pkg.sv
`default_nettype none
// ============================================================================
// usb_ep_status_bus_pkg : state type for the EP-status aux-port bus requester
// Rev 1.0
// ============================================================================
package usb_ep_status_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/usb_ep_status_bus.sv
`default_nettype none
// ============================================================================
// usb_ep_status_bus : single-beat register-bus requester for the EP-status
//                     RAM aux port, with microcode-ROM write protection
// Rev 1.0
// ============================================================================
module usb_ep_status_bus
    import usb_ep_status_bus_pkg::*;
#(
    parameter bit ROM_WP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  bus_addr,
    input  logic [15:0] bus_din,
    input  logic        bus_we,
    input  logic        bus_cyc,
    output logic [15:0] bus_dout,
    output logic        bus_ack,
    output logic [8:0]  s_addr_0,
    output logic        s_read_0,
    output logic        s_zero_0,
    output logic        s_write_0,
    output logic [15:0] s_din_0,
    input  logic [15:0] s_dout_3,
    input  logic        s_ready_0
);

    // Must equal the aux-port read pipeline depth: s_dout_3 carries the data
    // three cycles after the cycle in which s_ready_0 accepted the read.
    localparam int         c_READ_LATENCY = 3;
    localparam logic [1:0] c_CNT_LOAD     = 2'(c_READ_LATENCY - 1);

    state_t      r_state,   w_state;
    logic        r_we,      w_we;
    logic        r_abort,   w_abort;
    logic [1:0]  r_cnt,     w_cnt;
    logic        r_bus_ack, w_bus_ack;
    logic [15:0] r_bus_dout, w_bus_dout;
    logic [8:0]  r_s_addr,  w_s_addr;
    logic [15:0] r_s_din,   w_s_din;
    logic        r_s_read,  w_s_read;
    logic        r_s_write, w_s_write;
    logic        w_lost;
    logic        w_protected;

    // Master gave up on this transaction at some point; finish quietly.
    assign w_lost      = r_abort | ~bus_cyc;
    assign w_protected = ROM_WP && bus_we && bus_addr[8];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_abort    <= 1'b0;
            r_cnt      <= 2'd0;
            r_bus_ack  <= 1'b0;
            r_bus_dout <= 16'd0;
            r_s_addr   <= 9'd0;
            r_s_din    <= 16'd0;
            r_s_read   <= 1'b0;
            r_s_write  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_we       <= w_we;
            r_abort    <= w_abort;
            r_cnt      <= w_cnt;
            r_bus_ack  <= w_bus_ack;
            r_bus_dout <= w_bus_dout;
            r_s_addr   <= w_s_addr;
            r_s_din    <= w_s_din;
            r_s_read   <= w_s_read;
            r_s_write  <= w_s_write;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_we       = r_we;
        w_abort    = r_abort;
        w_cnt      = r_cnt;
        w_bus_ack  = 1'b0;
        w_bus_dout = 16'd0;
        w_s_addr   = r_s_addr;
        w_s_din    = r_s_din;
        w_s_read   = r_s_read;
        w_s_write  = r_s_write;

        case (r_state)
            ST_IDLE: begin
                w_abort = 1'b0;
                if (bus_cyc && !r_bus_ack) begin
                    w_s_addr = bus_addr;
                    w_s_din  = bus_din;
                    w_we     = bus_we;
                    if (w_protected) begin
                        w_bus_ack = 1'b1;
                        w_state   = ST_ACK;
                    end else begin
                        w_s_write = bus_we;
                        w_s_read  = ~bus_we;
                        w_state   = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                w_abort = w_lost;
                if (s_ready_0) begin
                    w_s_read  = 1'b0;
                    w_s_write = 1'b0;
                    if (!r_we) begin
                        w_cnt   = c_CNT_LOAD;
                        w_state = ST_WAIT;
                    end else if (w_lost) begin
                        w_state = ST_IDLE;
                    end else begin
                        w_bus_ack = 1'b1;
                        w_state   = ST_ACK;
                    end
                end
            end

            ST_WAIT: begin
                w_abort = w_lost;
                if (r_cnt == 2'd0) begin
                    if (w_lost) begin
                        w_state = ST_IDLE;
                    end else begin
                        w_bus_ack  = 1'b1;
                        w_bus_dout = s_dout_3;
                        w_state    = ST_ACK;
                    end
                end else begin
                    w_cnt = r_cnt - 2'd1;
                end
            end

            ST_ACK: begin
                w_state = ST_IDLE;
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign bus_ack   = r_bus_ack;
    assign bus_dout  = r_bus_dout;
    assign s_addr_0  = r_s_addr;
    assign s_din_0   = r_s_din;
    assign s_read_0  = r_s_read;
    assign s_write_0 = r_s_write;
    assign s_zero_0  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_usb_ep_status_bus.sv
`default_nettype none
// ============================================================================
// tb_usb_ep_status_bus : scoreboard bench with a behavioural aux-port RAM
// Rev 1.0
// ============================================================================
module tb_usb_ep_status_bus;

    typedef struct {
        int          start;
        int          kind;     // 0 write, 1 read, 2 protected write
        logic [15:0] data;
    } exp_t;

    typedef struct {
        int          start;
        bit          we;
        logic [8:0]  addr;
        logic [15:0] din;
    } req_t;

    typedef struct {
        int          due;
        logic [15:0] d;
    } pipe_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  bus_addr;
    logic [15:0] bus_din;
    logic        bus_we;
    logic        bus_cyc;
    logic [15:0] bus_dout;
    logic        bus_ack;
    logic [8:0]  s_addr_0;
    logic        s_read_0;
    logic        s_zero_0;
    logic        s_write_0;
    logic [15:0] s_din_0;
    logic [15:0] s_dout_3;
    logic        s_ready_0;

    logic [8:0]  d0_bus_addr;
    logic [15:0] d0_bus_din;
    logic        d0_bus_we;
    logic        d0_bus_cyc;
    logic [15:0] d0_bus_dout;
    logic        d0_bus_ack;
    logic [8:0]  d0_s_addr_0;
    logic        d0_s_read_0;
    logic        d0_s_zero_0;
    logic        d0_s_write_0;
    logic [15:0] d0_s_din_0;
    logic [15:0] d0_s_dout_3;
    logic        d0_s_ready_0;

    int          cyc_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    req_t        req_q[$];
    pipe_t       pipe_q[$];
    logic [15:0] aux_mem[512];
    logic [15:0] ref_mem[512];
    bit          rand_ready = 1'b0;
    int          stall_force = 0;
    int          last_accept = 0;
    int          stall_run = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    usb_ep_status_bus #(.ROM_WP(1'b1)) dut (
        .clk(clk), .rst(rst),
        .bus_addr(bus_addr), .bus_din(bus_din), .bus_we(bus_we), .bus_cyc(bus_cyc),
        .bus_dout(bus_dout), .bus_ack(bus_ack),
        .s_addr_0(s_addr_0), .s_read_0(s_read_0), .s_zero_0(s_zero_0),
        .s_write_0(s_write_0), .s_din_0(s_din_0), .s_dout_3(s_dout_3),
        .s_ready_0(s_ready_0)
    );

    usb_ep_status_bus #(.ROM_WP(1'b0)) dut_nowp (
        .clk(clk), .rst(rst),
        .bus_addr(d0_bus_addr), .bus_din(d0_bus_din), .bus_we(d0_bus_we), .bus_cyc(d0_bus_cyc),
        .bus_dout(d0_bus_dout), .bus_ack(d0_bus_ack),
        .s_addr_0(d0_s_addr_0), .s_read_0(d0_s_read_0), .s_zero_0(d0_s_zero_0),
        .s_write_0(d0_s_write_0), .s_din_0(d0_s_din_0), .s_dout_3(d0_s_dout_3),
        .s_ready_0(d0_s_ready_0)
    );

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    // Aux port of the status RAM: random backpressure, 3-cycle read pipe.
    initial begin : aux_port
        bit ready;
        s_ready_0 = 1'b0;
        s_dout_3  = 16'd0;
        for (int i = 0; i < 512; i++) aux_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (pipe_q.size() > 0 && pipe_q[0].due == cyc_cnt) begin
                s_dout_3 = pipe_q[0].d;
                void'(pipe_q.pop_front());
            end else begin
                s_dout_3 = 16'($urandom);
            end
            if (!rst && (s_read_0 || s_write_0)) begin
                checks++;
                if (req_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_request: got rd=%0b wr=%0b addr=%h din=%h, required no request",
                             s_read_0, s_write_0, s_addr_0, s_din_0);
                end else if (s_read_0 == s_write_0 || s_write_0 != req_q[0].we ||
                             s_addr_0 != req_q[0].addr || (s_write_0 && s_din_0 != req_q[0].din)) begin
                    errors++;
                    $display("FAIL req_fields: got rd=%0b wr=%0b addr=%h din=%h, required we=%0b addr=%h din=%h",
                             s_read_0, s_write_0, s_addr_0, s_din_0, req_q[0].we, req_q[0].addr, req_q[0].din);
                end
                if (stall_run < stall_force) ready = 1'b0;
                else ready = rand_ready ? ($urandom_range(2) != 0) : 1'b1;
                s_ready_0 = ready;
                if (ready) begin
                    if (req_q.size() > 0) begin
                        checks++;
                        if (cyc_cnt != req_q[0].start + 1 + stall_run) begin
                            errors++;
                            $display("FAIL issue_latency: accepted at cycle %0d, required %0d",
                                     cyc_cnt, req_q[0].start + 1 + stall_run);
                        end
                        void'(req_q.pop_front());
                    end
                    last_accept = cyc_cnt;
                    stall_run   = 0;
                    if (s_write_0) aux_mem[s_addr_0] = s_din_0;
                    else pipe_q.push_back('{cyc_cnt + 3, aux_mem[s_addr_0]});
                end else begin
                    stall_run++;
                end
            end else begin
                s_ready_0 = 1'($urandom);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        int   want;
        forever begin
            @(negedge clk);
            if (!rst) begin
                checks++;
                if ((!bus_ack && bus_dout != 16'd0) || s_zero_0) begin
                    errors++;
                    $display("FAIL idle_outputs: got ack=%0b dout=%h zero=%0b, required dout=0 zero=0",
                             bus_ack, bus_dout, s_zero_0);
                end
                if (bus_ack) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_ack: got ack at cycle %0d, required none", cyc_cnt);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus_dout != e.data) begin
                            errors++;
                            $display("FAIL ack_data: got %h, required %h", bus_dout, e.data);
                        end
                        checks++;
                        want = (e.kind == 2) ? e.start + 1 :
                               (e.kind == 0) ? last_accept + 1 : last_accept + 4;
                        if (cyc_cnt != want) begin
                            errors++;
                            $display("FAIL ack_latency: got cycle %0d, required %0d (kind %0d)",
                                     cyc_cnt, want, e.kind);
                        end
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        bus_cyc = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_txn(input bit we, input logic [8:0] addr, input logic [15:0] din, input bit chain);
        int   start;
        bit   prot;
        bit   got;
        exp_t e;
        start   = chain ? cyc_cnt + 1 : cyc_cnt;
        bus_cyc = 1'b1;
        bus_we  = we;
        bus_addr = addr;
        bus_din = din;
        prot    = we && addr[8];
        e.start = start;
        e.kind  = prot ? 2 : (we ? 0 : 1);
        e.data  = we ? 16'd0 : ref_mem[addr];
        exp_q.push_back(e);
        if (!prot) begin
            req_q.push_back('{start, we, addr, din});
            if (we) ref_mem[addr] = din;
        end
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = bus_ack;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout: got no ack for addr %h we %0b, required ack", addr, we);
        end
    endtask

    task automatic nowp_write;
        int  start, wr_cyc, ack_cyc;
        bit  wr_ok;
        d0_bus_cyc  = 1'b1;
        d0_bus_we   = 1'b1;
        d0_bus_addr = 9'h1A0;
        d0_bus_din  = 16'hCAFE;
        start   = cyc_cnt;
        wr_cyc  = -1;
        ack_cyc = -1;
        wr_ok   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (d0_s_write_0 && wr_cyc < 0) begin
                wr_cyc = cyc_cnt;
                wr_ok  = (d0_s_addr_0 == 9'h1A0) && (d0_s_din_0 == 16'hCAFE);
            end
            if (d0_bus_ack && ack_cyc < 0) begin
                ack_cyc    = cyc_cnt;
                d0_bus_cyc = 1'b0;
            end
        end
        checks++;
        if (wr_cyc != start + 1 || !wr_ok) begin
            errors++;
            $display("FAIL nowp_issue: got write at cycle %0d fields_ok=%0b, required cycle %0d fields_ok=1",
                     wr_cyc, wr_ok, start + 1);
        end
        checks++;
        if (ack_cyc != start + 2) begin
            errors++;
            $display("FAIL nowp_ack: got ack at cycle %0d, required %0d", ack_cyc, start + 2);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        bit          chain;
        bit          we;
        logic [8:0]  addr;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
        rst = 1'b1;
        bus_cyc = 1'b0; bus_we = 1'b0; bus_addr = 9'd0; bus_din = 16'd0;
        d0_bus_cyc = 1'b0; d0_bus_we = 1'b0; d0_bus_addr = 9'd0; d0_bus_din = 16'd0;
        d0_s_ready_0 = 1'b1; d0_s_dout_3 = 16'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_ack || bus_dout != 0 || s_read_0 || s_write_0 || s_zero_0 || s_addr_0 != 0 || s_din_0 != 0) begin
            errors++;
            $display("FAIL reset_state: got ack=%0b dout=%h rd=%0b wr=%0b addr=%h din=%h, required all 0",
                     bus_ack, bus_dout, s_read_0, s_write_0, s_addr_0, s_din_0);
        end
        rst = 1'b0;
        @(negedge clk);

        nowp_write();

        rand_ready = 1'b0;
        run_txn(1'b1, 9'h005, 16'h1234, 1'b0); idle(2);
        run_txn(1'b0, 9'h005, 16'h0000, 1'b0); idle(2);
        stall_force = 4;
        run_txn(1'b0, 9'h005, 16'h0000, 1'b0); idle(2);
        stall_force = 0;
        run_txn(1'b1, 9'h1A0, 16'hDEAD, 1'b0); idle(2);
        run_txn(1'b0, 9'h1A0, 16'h0000, 1'b0); idle(2);
        run_txn(1'b1, 9'h033, 16'hA5A5, 1'b0);
        run_txn(1'b0, 9'h033, 16'h0000, 1'b1); idle(2);

        // Reset while the read sits in its latency wait: no ack may follow.
        bus_cyc = 1'b1; bus_we = 1'b0; bus_addr = 9'h0AB;
        req_q.push_back('{cyc_cnt, 1'b0, 9'h0AB, bus_din});
        for (int i = 0; i < 50 && req_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus_cyc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus_ack || bus_dout != 0 || s_read_0 || s_write_0 || s_addr_0 != 0 || s_din_0 != 0) begin
            errors++;
            $display("FAIL mid_reset: got ack=%0b dout=%h rd=%0b wr=%0b addr=%h din=%h, required all 0",
                     bus_ack, bus_dout, s_read_0, s_write_0, s_addr_0, s_din_0);
        end
        idle(6);
        run_txn(1'b0, 9'h0AB, 16'h0000, 1'b0); idle(2);

        // Master drops bus_cyc while the read is pending.
        bus_cyc = 1'b1; bus_we = 1'b0; bus_addr = 9'h012;
        req_q.push_back('{cyc_cnt, 1'b0, 9'h012, bus_din});
        @(negedge clk);
        idle(12);
        run_txn(1'b0, 9'h012, 16'h0000, 1'b0); idle(2);

        rand_ready = 1'b1;
        chain = 1'b0;
        for (int n = 0; n < 60; n++) begin
            we   = 1'($urandom);
            addr = ($urandom_range(3) == 0) ? {1'b1, 8'($urandom_range(3))} : {6'd0, 3'($urandom)};
            run_txn(we, addr, 16'($urandom), chain);
            if ($urandom_range(1) == 1) begin
                chain = 1'b1;
            end else begin
                chain = 1'b0;
                idle(1 + $urandom_range(2));
            end
        end
        idle(20);
        checks++;
        if (exp_q.size() != 0 || req_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d acks and %0d requests outstanding, required 0 and 0",
                     exp_q.size(), req_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
